level_scheduler: RTL and testbench

LEVEL_SCHEDULER -- requirements
Module: level_scheduler

---
 rtl/level_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/level_scheduler.sv | 156 +++++++++++++++
 tb/tb_level_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared definitions for the level scheduler: FSM encoding and the
// accumulator width rule.
package level_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Wide enough for 2^window_log2 squares of full-scale samples.
  function automatic int sum_w(input int data_w, input int window_log2);
    return 2 * data_w + window_log2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester;
// the pointer moves only when a grant is issued.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
    ptr_d = ptr_q;
    if (clear) ptr_d = '0;
    else if (found) ptr_d = IDX_W'((int'(grant_idx) + 1) % N);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/level_scheduler.sv
// Time-shares one square-accumulate datapath across NUM_CH channels and
// hands completed window sums of squares to a downstream converter.
module level_scheduler
  import level_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int DATA_W      = 8,
  parameter  int WINDOW_LOG2 = 10,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SUM_W       = sum_w(DATA_W, WINDOW_LOG2)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CH_W-1:0]          res_ch,
  output logic [SUM_W-1:0]         res_sum,
  output logic                     busy,
  output state_e                   dbg_state
);

  localparam logic [WINDOW_LOG2-1:0] CNT_MAX = '1;

  // Handshakes: a sample moves when ch_valid[i] & ch_ready[i]; a result moves
  // when res_valid & res_ready, and the result holds steady until then.
  state_e                  state_q, state_d;
  logic [WINDOW_LOG2-1:0]  cnt_q [NUM_CH];
  logic [WINDOW_LOG2-1:0]  cnt_d [NUM_CH];
  logic [SUM_W-1:0]        acc_q [NUM_CH];
  logic [SUM_W-1:0]        acc_d [NUM_CH];
  logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [CH_W-1:0]         s1_ch_q, s1_ch_d;
  logic [2*DATA_W-1:0]     s1_sq_q, s1_sq_d;
  logic                    res_valid_q, res_valid_d;
  logic [CH_W-1:0]         res_ch_q, res_ch_d;
  logic [SUM_W-1:0]        res_sum_q, res_sum_d;

  logic [NUM_CH-1:0]       eligible, grant;
  logic [CH_W-1:0]         grant_idx;
  logic                    grant_en, accept;
  logic [DATA_W-1:0]       sample;
  logic [2*DATA_W-1:0]     sample_ext;
  logic [SUM_W-1:0]        stage2_sum;

  // A window-last sample may only enter when its result has a free slot.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = ch_valid[i] &&
                    ((cnt_q[i] != CNT_MAX) || (!res_valid_q && !(s1_valid_q && s1_last_q)));
    end
  end

  assign grant_en = (state_q == ST_RUN) && !clear;

  rr_arbiter #(.N(NUM_CH), .IDX_W(CH_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .en        (grant_en),
    .req       (eligible),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign ch_ready   = grant;
  assign accept     = |grant;
  assign sample     = ch_data[grant_idx*DATA_W +: DATA_W];
  assign sample_ext = {{DATA_W{1'b0}}, sample};
  assign stage2_sum = acc_q[s1_ch_q] + SUM_W'(s1_sq_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: if (enable) state_d = ST_RUN;
                else if (!s1_valid_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    s1_valid_d  = 1'b0;
    s1_ch_d     = s1_ch_q;
    s1_sq_d     = s1_sq_q;
    s1_last_d   = s1_last_q;
    res_valid_d = res_valid_q && !res_ready;
    res_ch_d    = res_ch_q;
    res_sum_d   = res_sum_q;

    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_d[i] = '0;
        acc_d[i] = '0;
      end
    end else begin
      if (s1_valid_q) begin
        if (s1_last_q) begin
          res_valid_d     = 1'b1;
          res_ch_d        = s1_ch_q;
          res_sum_d       = stage2_sum;
          acc_d[s1_ch_q]  = '0;
        end else begin
          acc_d[s1_ch_q]  = stage2_sum;
        end
      end
      if (accept) begin
        s1_valid_d       = 1'b1;
        s1_ch_d          = grant_idx;
        s1_sq_d          = sample_ext * sample_ext;
        s1_last_d        = (cnt_q[grant_idx] == CNT_MAX);
        cnt_d[grant_idx] = cnt_q[grant_idx] + WINDOW_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        acc_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      s1_sq_q     <= '0;
      s1_last_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      s1_valid_q  <= s1_valid_d;
      s1_ch_q     <= s1_ch_d;
      s1_sq_q     <= s1_sq_d;
      s1_last_q   <= s1_last_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_sum_q   <= res_sum_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_sum   = res_sum_q;
  assign busy      = (state_q != ST_IDLE) || s1_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_level_scheduler.sv
// Bench for level_scheduler with 4-sample windows: directed scenarios plus
// randomized traffic against a window-level reference model.
module tb_level_scheduler;
  import level_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int WL2    = 2;
  localparam int WIN    = 4;
  localparam int SUM_W  = 2 * DATA_W + WL2;
  localparam int CH_W   = 2;
  localparam int W      = CH_W + SUM_W;

  logic                     clk = 1'b0;
  logic                     rst, enable, clear, res_ready;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid, ch_ready;
  logic                     res_valid, busy;
  logic [CH_W-1:0]          res_ch;
  logic [SUM_W-1:0]         res_sum;
  state_e                   dbg_state;

  level_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WINDOW_LOG2(WL2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ch_data(ch_data),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_sum(res_sum), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] exp_q[$];
  int     m_state, m_ptr, m_pch;
  int     m_cnt [NUM_CH];
  longint m_run [NUM_CH];
  bit     m_pv, m_pl, m_rv;
  longint m_psum;
  int     rem [NUM_CH], fix_val [NUM_CH], n_acc [NUM_CH];
  bit     gappy;
  int     n_res, n_rv_cycles, last_ch;
  longint last_sum;
  int     dut_seq[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_pch = 0; m_pv = 0; m_pl = 0; m_rv = 0; m_psum = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0;
      m_run[c] = 0;
    end
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_valid[c] = (rem[c] > 0) && (!gappy || $urandom_range(0, 3) != 0);
      ch_data[c*DATA_W +: DATA_W] = (fix_val[c] >= 0) ? DATA_W'(fix_val[c])
                                                       : DATA_W'($urandom_range(0, 255));
    end
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance it.
  task automatic tick();
    int g;
    bit old_pv, load;
    longint sq;
    logic [NUM_CH-1:0] ready_exp;
    @(negedge clk);
    g = -1;
    if (!rst && m_state == 1 && !clear) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_ptr + k) % NUM_CH;
        if (g < 0 && ch_valid[c] && (m_cnt[c] != WIN - 1 || (!m_rv && !(m_pv && m_pl)))) g = c;
      end
    end
    ready_exp = '0;
    if (g >= 0) ready_exp[g] = 1'b1;
    check("ch_ready", ch_ready, ready_exp);
    check("res_valid", res_valid, m_rv);
    check("busy", busy, (m_state != 0) || m_pv);
    if (res_valid && exp_q.size() > 0) check("res_word", {res_ch, res_sum}, exp_q[0]);
    if (res_valid) n_rv_cycles++;
    if (res_valid && res_ready) begin
      n_res++;
      last_sum = res_sum;
      last_ch  = res_ch;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_valid[c] && ch_ready[c]) begin
        n_acc[c]++;
        dut_seq.push_back(c);
        if (rem[c] > 0) rem[c]--;
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      old_pv = m_pv;
      load   = 0;
      if (!clear && m_pv && m_pl) begin
        exp_q.push_back({CH_W'(m_pch), SUM_W'(m_psum)});
        load = 1;
      end
      if (m_rv && res_ready) m_rv = 0;
      if (load) m_rv = 1;
      if (clear) begin
        for (int c = 0; c < NUM_CH; c++) begin
          m_cnt[c] = 0;
          m_run[c] = 0;
        end
        m_ptr = 0;
        m_pv  = 0;
      end else if (g >= 0) begin
        sq       = longint'(ch_data[g*DATA_W +: DATA_W]) * longint'(ch_data[g*DATA_W +: DATA_W]);
        m_pv     = 1;
        m_pch    = g;
        m_pl     = (m_cnt[g] == WIN - 1);
        m_psum   = m_run[g] + sq;
        m_run[g] = m_pl ? 0 : m_psum;
        m_cnt[g] = (m_cnt[g] + 1) % WIN;
        m_ptr    = (g + 1) % NUM_CH;
      end else begin
        m_pv = 0;
      end
      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = 2;
        default: if (enable) m_state = 1; else if (!old_pv) m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    drive_inputs();
    while (n < budget && ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 || m_pv || m_rv)) begin
      tick();
      n++;
    end
    if (n >= budget) check("done_timeout", 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; res_ready = 1'b0;
    ch_valid = '0; ch_data = '0; gappy = 0;
    n_res = 0; n_rv_cycles = 0; last_ch = 0; last_sum = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      rem[c] = 0; fix_val[c] = -1; n_acc[c] = 0;
    end
    model_reset();
    #1;
    check("rst_ch_ready", ch_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_ch", res_ch, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single window of 10s on channel 0
    enable = 1'b1; res_ready = 1'b1;
    fix_val[0] = 10; rem[0] = 4;
    base = n_res;
    run_until_done(40);
    repeat (3) tick();
    check("t1_sum", last_sum, 400);
    check("t1_ch", last_ch, 0);
    check("t1_nres", n_res - base, 1);

    // all channels requesting: grants rotate 0,1,2,3
    pulse_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      fix_val[c] = -1; rem[c] = 3;
    end
    dut_seq.delete();
    run_until_done(60);
    check("t2_len", dut_seq.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < dut_seq.size()) check($sformatf("t2_grant%0d", k), dut_seq[k], k % NUM_CH);
    end

    // two windows completing while the result is not taken
    pulse_clear();
    res_ready = 1'b0;
    fix_val[0] = $urandom_range(0, 255); fix_val[1] = $urandom_range(0, 255);
    rem[0] = 4; rem[1] = 4;
    n_acc[0] = 0; n_acc[1] = 0;
    base = n_res;
    drive_inputs();
    repeat (30) tick();
    check("t3_ch0_acc", n_acc[0], 4);
    check("t3_ch1_held", n_acc[1], 3);
    res_ready = 1'b1;
    run_until_done(60);
    check("t3_nres", n_res - base, 2);

    // clear discards a partial window
    pulse_clear();
    fix_val[0] = 255; rem[0] = 2;
    run_until_done(40);
    pulse_clear();
    fix_val[0] = 1; rem[0] = 4;
    run_until_done(40);
    check("t4_sum", last_sum, 4);

    // enable drop retains the partial window
    pulse_clear();
    fix_val[0] = 3; rem[0] = 2;
    run_until_done(40);
    enable = 1'b0;
    repeat (50) tick();
    check("t5_busy", busy, 0);
    check("t5_state", dbg_state, ST_IDLE);
    enable = 1'b1; rem[0] = 2;
    run_until_done(40);
    check("t5_sum", last_sum, 36);

    // randomized traffic
    pulse_clear();
    gappy = 1;
    for (int c = 0; c < NUM_CH; c++) fix_val[c] = -1;
    for (int n = 0; n < 800; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rem[c] == 0 && $urandom_range(0, 7) == 0) rem[c] = $urandom_range(1, 6);
      end
      drive_inputs();
      tick();
    end
    clear = 1'b0; enable = 1'b1; res_ready = 1'b1; gappy = 0;
    run_until_done(300);
    check("rand_q_empty", exp_q.size(), 0);

    // reset while stage 2 is working on a window-last sample
    pulse_clear();
    fix_val[0] = 7; rem[0] = 4;
    drive_inputs();
    begin
      int n;
      n = 0;
      while (n < 40 && !(m_pv && m_pl)) begin
        tick();
        n++;
      end
      if (n >= 40) check("t6_timeout", 1, 0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("t6_ch_ready", ch_ready, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_res_ch", res_ch, 0);
    check("t6_res_sum", res_sum, 0);
    check("t6_busy", busy, 0);
    model_reset();
    for (int c = 0; c < NUM_CH; c++) rem[c] = 0;
    drive_inputs();
    repeat (2) tick();
    rst = 1'b0;
    base = n_rv_cycles;
    repeat (10) tick();
    check("t6_no_result", n_rv_cycles - base, 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
